// File: rtl/asrv32_memoryaccess_pkg.sv
// Access-size decode and byte-lane helpers for the memory-access stage.
package asrv32_memoryaccess_pkg;
`include "asrv32_header.vh"

  localparam int OPCODE_WIDTH = `OPCODE_WIDTH;
  localparam int OP_RTYPE     = `OPCODE_RTYPE;
  localparam int OP_LOAD      = `OPCODE_LOAD;
  localparam int OP_STORE     = `OPCODE_STORE;

  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;

  // Stores share the load encodings for size; the reserved codes fall back to word.
  function automatic size_e access_size(input logic [2:0] funct3);
    case (funct3)
      `FUNCT3_LB, `FUNCT3_LBU: return SIZE_BYTE;
      `FUNCT3_LH, `FUNCT3_LHU: return SIZE_HALF;
      default:                 return SIZE_WORD;
    endcase
  endfunction

  function automatic logic is_aligned(input size_e size, input logic [1:0] addr);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr[0];
      default:   return addr == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input size_e size, input logic [1:0] addr);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr;
      SIZE_HALF: return 4'b0011 << {addr[1], 1'b0};
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input size_e size, input logic [31:0] rs2);
    case (size)
      SIZE_BYTE: return {4{rs2[7:0]}};
      SIZE_HALF: return {2{rs2[15:0]}};
      default:   return rs2;
    endcase
  endfunction

endpackage

// File: rtl/asrv32_header.vh
// Opcode bit positions shared with the writeback stage, and RV32 load/store funct3 codes.
`ifndef ASRV32_HEADER_VH
`define ASRV32_HEADER_VH

`define OPCODE_WIDTH   11
`define OPCODE_RTYPE   0
`define OPCODE_ITYPE   1
`define OPCODE_LOAD    2
`define OPCODE_STORE   3
`define OPCODE_BRANCH  4
`define OPCODE_JAL     5
`define OPCODE_JALR    6
`define OPCODE_LUI     7
`define OPCODE_AUIPC   8
`define OPCODE_SYSTEM  9
`define OPCODE_FENCE   10

`define FUNCT3_LB      3'b000
`define FUNCT3_LH      3'b001
`define FUNCT3_LW      3'b010
`define FUNCT3_LBU     3'b100
`define FUNCT3_LHU     3'b101
`define FUNCT3_SB      3'b000
`define FUNCT3_SH      3'b001
`define FUNCT3_SW      3'b010

`endif

// File: rtl/asrv32_memoryaccess_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational.
`include "asrv32_header.vh"

module asrv32_load_align (
  input  logic [31:0] data,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[7:0];
    case (addr)
      2'd0: byte_sel = data[7:0];
      2'd1: byte_sel = data[15:8];
      2'd2: byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    half_sel = addr[1] ? data[31:16] : data[15:0];

    case (funct3)
      `FUNCT3_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      `FUNCT3_LBU: load_data = {24'h0, byte_sel};
      `FUNCT3_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      `FUNCT3_LHU: load_data = {16'h0, half_sel};
      default:     load_data = data;
    endcase
  end

endmodule

// File: rtl/asrv32_memoryaccess.sv
// MEMORYACCESS stage: one Wishbone data transfer per start pulse, done pulse on completion.
// Latency: 1 cycle for non-memory/misaligned ops; bus ops wait out stall and ack.
`include "asrv32_header.vh"

module asrv32_memoryaccess
  import asrv32_memoryaccess_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_memoryaccess_en,
  input  logic [`OPCODE_WIDTH-1:0] i_opcode,
  input  logic [2:0]               i_funct3,
  input  logic [31:0]              i_addr,
  input  logic [31:0]              i_rs2_data,
  output logic [31:0]              o_load_data,
  output logic                     o_done,
  output logic                     o_misaligned,
  output logic                     o_busy,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [31:0]              o_wb_addr,
  output logic [31:0]              o_wb_data,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_stall,
  input  logic [31:0]              i_wb_data
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] load_aligned;
  logic        start_mem;
  logic        start_ok;
  size_e       start_size;
  logic        unused_opcode;

  assign start_mem     = i_opcode[`OPCODE_LOAD] | i_opcode[`OPCODE_STORE];
  assign start_size    = access_size(i_funct3);
  assign start_ok      = is_aligned(start_size, i_addr[1:0]);
  assign unused_opcode = ^i_opcode;

  asrv32_load_align u_load_align (
    .data      (i_wb_data),
    .addr      (addr_lo_q),
    .funct3    (funct3_q),
    .load_data (load_aligned)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      funct3_q     <= 3'b000;
      addr_lo_q    <= 2'b00;
      o_load_data  <= 32'h0;
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      o_busy       <= 1'b0;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= 32'h0;
      o_wb_data    <= 32'h0;
      o_wb_sel     <= 4'h0;
    end else begin
      o_done       <= 1'b0;
      o_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (i_memoryaccess_en) begin
            funct3_q  <= i_funct3;
            addr_lo_q <= i_addr[1:0];
            o_busy    <= 1'b1;
            if (start_mem && start_ok) begin
              state     <= REQ;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_opcode[`OPCODE_STORE];
              o_wb_addr <= {i_addr[31:2], 2'b00};
              o_wb_sel  <= lane_sel(start_size, i_addr[1:0]);
              o_wb_data <= lane_data(start_size, i_rs2_data);
            end else begin
              // Non-memory ops and misaligned accesses complete without touching the bus.
              state        <= DONE;
              o_done       <= 1'b1;
              o_misaligned <= start_mem;
            end
          end
        end
        REQ: begin
          if (!i_wb_stall) begin
            o_wb_stb <= 1'b0;
            if (i_wb_ack) begin
              state    <= DONE;
              o_wb_cyc <= 1'b0;
              o_done   <= 1'b1;
              if (!o_wb_we) o_load_data <= load_aligned;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (i_wb_ack) begin
            state    <= DONE;
            o_wb_cyc <= 1'b0;
            o_done   <= 1'b1;
            if (!o_wb_we) o_load_data <= load_aligned;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asrv32_memoryaccess.sv
// Directed-vector bench for asrv32_memoryaccess with an acking bus model driven per vector.
module tb_asrv32_memoryaccess;
  import asrv32_memoryaccess_pkg::*;

  logic                    i_clk = 1'b0;
  logic                    i_rst = 1'b1;
  logic                    i_memoryaccess_en = 1'b0;
  logic [OPCODE_WIDTH-1:0] i_opcode = '0;
  logic [2:0]              i_funct3 = 3'b000;
  logic [31:0]             i_addr = 32'h0;
  logic [31:0]             i_rs2_data = 32'h0;
  logic [31:0]             o_load_data;
  logic                    o_done, o_misaligned, o_busy;
  logic                    o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0]             o_wb_addr, o_wb_data;
  logic [3:0]              o_wb_sel;
  logic                    i_wb_ack = 1'b0;
  logic                    i_wb_stall = 1'b0;
  logic [31:0]             i_wb_data = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_load = 32'h0;

  always #5 i_clk = ~i_clk;

  asrv32_memoryaccess dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_memoryaccess_en(i_memoryaccess_en),
    .i_opcode(i_opcode), .i_funct3(i_funct3), .i_addr(i_addr), .i_rs2_data(i_rs2_data),
    .o_load_data(o_load_data), .o_done(o_done), .o_misaligned(o_misaligned), .o_busy(o_busy),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .i_wb_data(i_wb_data)
  );

  typedef struct {
    int          op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          stall;
    bit          ack_same;
    bit          is_bus;
    logic [3:0]  sel;
    logic [31:0] wdata;
    bit          we;
    bit          mis;
    bit          is_load;
    logic [31:0] load;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input int op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata, input int stall,
                              input bit ack_same, input bit is_bus, input logic [3:0] sel,
                              input logic [31:0] wdata, input bit mis, input logic [31:0] load);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.stall = stall;
    v.ack_same = ack_same; v.is_bus = is_bus; v.sel = sel; v.wdata = wdata;
    v.we = (op == OP_STORE); v.mis = mis; v.is_load = (op == OP_LOAD); v.load = load;
    return v;
  endfunction

  function automatic logic [OPCODE_WIDTH-1:0] onehot(input int idx);
    logic [OPCODE_WIDTH-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge i_clk);
    i_memoryaccess_en = 1'b1;
    i_opcode   = onehot(v.op);
    i_funct3   = v.f3;
    i_addr     = v.addr;
    i_rs2_data = v.rs2;
    i_wb_stall = (v.stall > 0);
    i_wb_ack   = 1'b0;
    @(negedge i_clk);
    i_memoryaccess_en = 1'b0;
    if (!v.is_bus) begin
      chk({t, " done"}, {31'h0, o_done}, 32'h1);
      chk({t, " misaligned"}, {31'h0, o_misaligned}, {31'h0, v.mis});
      chk({t, " cyc idle"}, {31'h0, o_wb_cyc}, 32'h0);
    end else begin
      chk({t, " cyc"}, {31'h0, o_wb_cyc}, 32'h1);
      chk({t, " stb"}, {31'h0, o_wb_stb}, 32'h1);
      chk({t, " we"}, {31'h0, o_wb_we}, {31'h0, v.we});
      chk({t, " sel"}, {28'h0, o_wb_sel}, {28'h0, v.sel});
      chk({t, " addr"}, o_wb_addr, {v.addr[31:2], 2'b00});
      if (v.we) chk({t, " wdata"}, o_wb_data, v.wdata);
      for (int s = 0; s < v.stall; s++) begin
        // Ack and a new start pulse while stalled must both be ignored.
        i_wb_ack = 1'b1;
        i_memoryaccess_en = 1'b1;
        i_opcode = onehot(OP_RTYPE);
        i_addr = 32'hFFFF_FFFF;
        @(negedge i_clk);
        chk({t, " stall stb"}, {31'h0, o_wb_stb}, 32'h1);
        chk({t, " stall done"}, {31'h0, o_done}, 32'h0);
        chk({t, " stall sel"}, {28'h0, o_wb_sel}, {28'h0, v.sel});
        chk({t, " stall addr"}, o_wb_addr, {v.addr[31:2], 2'b00});
        if (v.we) chk({t, " stall wdata"}, o_wb_data, v.wdata);
      end
      i_memoryaccess_en = 1'b0;
      i_wb_stall = 1'b0;
      i_wb_ack = v.ack_same;
      i_wb_data = v.rdata;
      @(negedge i_clk);
      if (!v.ack_same) begin
        chk({t, " wait cyc"}, {31'h0, o_wb_cyc}, 32'h1);
        chk({t, " wait stb"}, {31'h0, o_wb_stb}, 32'h0);
        chk({t, " wait done"}, {31'h0, o_done}, 32'h0);
        i_wb_ack = 1'b1;
        @(negedge i_clk);
      end
      i_wb_ack = 1'b0;
      chk({t, " done"}, {31'h0, o_done}, 32'h1);
      chk({t, " misaligned"}, {31'h0, o_misaligned}, 32'h0);
      chk({t, " cyc end"}, {31'h0, o_wb_cyc}, 32'h0);
    end
    if (v.is_load && !v.mis) last_load = v.load;
    chk({t, " load_data"}, o_load_data, last_load);
    @(negedge i_clk);
    chk({t, " done clear"}, {31'h0, o_done}, 32'h0);
    chk({t, " busy clear"}, {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    //            op        f3      addr          rs2           rdata        st ack bus sel    wdata         mis load
    vecs[0]  = mk(OP_STORE, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
    vecs[1]  = mk(OP_LOAD,  3'b000, 32'h0000_0103, 32'h0,         32'h80FF_FF7F, 0, 0, 1, 4'h8, 32'h0,        0, 32'hFFFF_FF80);
    vecs[2]  = mk(OP_LOAD,  3'b100, 32'h0000_0103, 32'h0,         32'h80FF_FF7F, 1, 0, 1, 4'h8, 32'h0,        0, 32'h0000_0080);
    vecs[3]  = mk(OP_STORE, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 0, 1, 4'hC, 32'hABCD_ABCD, 0, 32'h0);
    vecs[4]  = mk(OP_LOAD,  3'b101, 32'h0000_0002, 32'h0,         32'hF00D_0000, 0, 1, 1, 4'hC, 32'h0,        0, 32'h0000_F00D);
    vecs[5]  = mk(OP_LOAD,  3'b010, 32'h0000_0101, 32'h0,         32'h0,        0, 0, 0, 4'h0, 32'h0,        1, 32'h0);
    vecs[6]  = mk(OP_RTYPE, 3'b000, 32'h0000_0101, 32'h0,         32'h0,        0, 0, 0, 4'h0, 32'h0,        0, 32'h0);
    vecs[7]  = mk(OP_STORE, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        0, 0, 1, 4'h2, 32'hA5A5_A5A5, 0, 32'h0);
    vecs[8]  = mk(OP_LOAD,  3'b001, 32'h0000_0010, 32'h0,         32'h1234_8001, 0, 1, 1, 4'h3, 32'h0,        0, 32'hFFFF_8001);
    vecs[9]  = mk(OP_LOAD,  3'b001, 32'h0000_0011, 32'h0,         32'h0,        0, 0, 0, 4'h0, 32'h0,        1, 32'h0);
    vecs[10] = mk(OP_STORE, 3'b011, 32'h0000_0020, 32'h1122_3344, 32'h0,        2, 1, 1, 4'hF, 32'h1122_3344, 0, 32'h0);
    vecs[11] = mk(OP_STORE, 3'b011, 32'h0000_0022, 32'h1122_3344, 32'h0,        0, 0, 0, 4'h0, 32'h0,        1, 32'h0);
    vecs[12] = mk(OP_LOAD,  3'b010, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1, 0, 1, 4'hF, 32'h0,        0, 32'hCAFE_F00D);
    vecs[13] = mk(OP_LOAD,  3'b100, 32'h0000_0041, 32'h0,         32'hCAFE_F00D, 0, 0, 1, 4'h2, 32'h0,        0, 32'h0000_00F0);
    vecs[14] = mk(OP_LOAD,  3'b110, 32'h0000_0044, 32'h0,         32'h0102_0304, 0, 1, 1, 4'hF, 32'h0,        0, 32'h0102_0304);
    vecs[15] = mk(OP_STORE, 3'b001, 32'h0000_0013, 32'h0,         32'h0,        0, 0, 0, 4'h0, 32'h0,        1, 32'h0);

    // Reset state
    @(negedge i_clk);
    chk("rst cyc",  {31'h0, o_wb_cyc}, 32'h0);
    chk("rst stb",  {31'h0, o_wb_stb}, 32'h0);
    chk("rst we",   {31'h0, o_wb_we}, 32'h0);
    chk("rst done", {31'h0, o_done}, 32'h0);
    chk("rst mis",  {31'h0, o_misaligned}, 32'h0);
    chk("rst busy", {31'h0, o_busy}, 32'h0);
    chk("rst addr", o_wb_addr, 32'h0);
    chk("rst data", o_wb_data, 32'h0);
    chk("rst sel",  {28'h0, o_wb_sel}, 32'h0);
    chk("rst load", o_load_data, 32'h0);
    i_rst = 1'b0;

    for (int i = 0; i < 16; i++) run_txn(i, vecs[i]);

    // Reset while waiting for ack: bus drops at once, later ack produces nothing.
    @(negedge i_clk);
    i_memoryaccess_en = 1'b1;
    i_opcode = onehot(OP_LOAD);
    i_funct3 = 3'b010;
    i_addr = 32'h0000_0050;
    i_wb_stall = 1'b0;
    i_wb_ack = 1'b0;
    @(negedge i_clk);
    i_memoryaccess_en = 1'b0;
    @(negedge i_clk);
    chk("rstwait cyc before", {31'h0, o_wb_cyc}, 32'h1);
    chk("rstwait stb before", {31'h0, o_wb_stb}, 32'h0);
    #2 i_rst = 1'b1;
    #1;
    chk("rstwait cyc async", {31'h0, o_wb_cyc}, 32'h0);
    chk("rstwait busy async", {31'h0, o_busy}, 32'h0);
    chk("rstwait load cleared", o_load_data, 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    i_wb_ack = 1'b1;
    i_wb_data = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      chk("rstwait late ack done", {31'h0, o_done}, 32'h0);
      chk("rstwait late ack cyc", {31'h0, o_wb_cyc}, 32'h0);
      chk("rstwait late ack load", o_load_data, 32'h0);
    end
    i_wb_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asrv32_memoryaccess.md
ASRV32_MEMORYACCESS -- requirements
Module: asrv32_memoryaccess

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: i_clk (rising edge) and i_rst (asynchronous, active-high).
REQ-002 SHALL provide these ports:
- i_clk  in  1  clock
- i_rst  in  1  async active-high reset
- i_memoryaccess_en  in  1  start pulse, asserted for one cycle when the core enters the MEMORYACCESS stage
- i_opcode  in  `OPCODE_WIDTH  one-hot opcode, using the same indices as the writeback stage
- i_funct3  in  3  access size and sign
- i_addr  in  32  effective address (ALU result)
- i_rs2_data  in  32  store source
- o_load_data  out  32  aligned, extended load value; feeds writeback i_load_data_from_memory
- o_done  out  1  one-cycle pulse marking stage complete
- o_misaligned  out  1  one-cycle pulse, coincident with o_done
- o_busy  out  1  high while the FSM is not IDLE
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  data-bus control
- o_wb_addr  out  32  word address {addr[31:2],2'b00}
- o_wb_data  out  32  lane-replicated store data
- o_wb_sel  out  4  byte enables
- i_wb_ack  in  1  transfer complete
- i_wb_stall  in  1  slave not accepting stb
- i_wb_data  in  32  read data

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-004 In IDLE with i_memoryaccess_en=1, SHALL latch opcode, funct3, addr and rs2_data.
REQ-005 Routing out of IDLE:
- LOAD/STORE, aligned: go to REQ.
- LOAD/STORE, misaligned: go to DONE with o_misaligned=1 and no bus cycle.
- Any other opcode: go to DONE, so o_done fires 1 cycle after start.
REQ-006 Alignment rule: halfword requires addr[0]=0; word requires addr[1:0]=0; byte is always aligned.
REQ-007 In REQ, cyc=stb=1 and all bus outputs SHALL stay stable. When i_wb_stall=0, the request is accepted:
- with i_wb_ack=1 in the same cycle: go to DONE;
- otherwise: go to WAIT with stb=0 and cyc=1.
REQ-008 In WAIT, on i_wb_ack SHALL capture i_wb_data and go to DONE. An ack arriving while stall=1 in REQ SHALL be ignored.
REQ-009 DONE SHALL last exactly 1 cycle: cyc=stb=0, o_done=1, return to IDLE.
REQ-010 i_memoryaccess_en while not IDLE SHALL be ignored.
REQ-011 Store lanes:
- SB: sel=4'b0001<<addr[1:0], data={4{rs2[7:0]}}
- SH: sel=4'b0011<<{addr[1],1'b0}, data={2{rs2[15:0]}}
- SW: sel=4'b1111, data=rs2
- o_wb_we=1
REQ-012 Load extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Loads SHALL drive sel as for stores of the same size, with o_wb_we=0.
REQ-013 o_load_data SHALL be registered, SHALL hold its value until the next load completes, and SHALL be valid when o_done=1.
REQ-014 Unsupported funct3 on LOAD/STORE (011, 110, 111) SHALL be treated as word size.

Reset
REQ-015 When i_rst=1, asynchronously: state=IDLE; cyc, stb, we, o_done, o_misaligned, o_busy = 0; o_wb_addr, o_wb_data, o_wb_sel, o_load_data = 0.
REQ-016 Reset mid-transaction SHALL drop cyc/stb immediately. A later ack SHALL be ignored in IDLE.

Structure
REQ-017 Shared `asrv32_header.vh` SHALL hold the opcode indices and the funct3 constants (`FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW`). FSM state encodings SHALL stay local to the module.
REQ-018 Load extraction and extension SHALL be a combinational sub-module, asrv32_load_align (inputs: data, addr[1:0], funct3).

Verification
REQ-019 SW: addr=0x100, rs2=0xDEADBEEF, stall=0, ack next cycle -> sel=1111, addr=0x100, we=1, o_done exactly 1 cycle after ack.
REQ-020 LB: addr=0x103, bus data=0x80FF_FF7F -> sel=1000, o_load_data=0xFFFFFF80. Same transfer as LBU -> 0x00000080.
REQ-021 SH: addr=0x202, rs2=0x1234ABCD, stall=1 for 3 cycles -> stb held 4 cycles with stable outputs, sel=1100, data=0xABCDABCD.
REQ-022 LW at addr=0x101 -> no cyc, o_misaligned=o_done=1 one cycle after start. ADD opcode -> o_done one cycle after start, o_misaligned=0.
REQ-023 Reset asserted in WAIT -> cyc=0 in the same cycle. A subsequent ack is ignored and no o_done fires.
REQ-024 Ack in the same cycle as acceptance (stall=0) -> DONE next cycle, with LHU addr=0x2 and data=0xF00D0000 giving o_load_data=0x0000F00D.
